// File: rtl/cart_loader_if.sv
// Bundles the host download port, the DDR3 toggle-handshake write port and loader status for cart_loader.
interface cart_loader_if;
    logic        dl;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_wait;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_req;
    logic        wr_ack;
    logic [24:0] rom_sz;
    logic [5:0]  quirks;
    logic        done;

    modport master (
        output dl, dl_wr, dl_addr, dl_data, wr_ack,
        input  dl_wait, wr_addr, wr_data, wr_req, rom_sz, quirks, done
    );

    modport slave (
        input  dl, dl_wr, dl_addr, dl_data, wr_ack,
        output dl_wait, wr_addr, wr_data, wr_req, rom_sz, quirks, done
    );
endinterface

// File: rtl/cart_loader.sv
// Streams a host cartridge download into the DDR3 ROM store, tracks image size and detects per-title quirks.
// Optional macro CART_QUIRK_EN enables header serial capture and the quirk table; otherwise quirks is constant 0.
module cart_loader (
    input  logic         mclk,
    input  logic         reset_n,
    cart_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, PEND, DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic        dl_q;
    logic        dl_rise;
    logic        ack_match;
    logic        do_start;
    logic        do_write;
    logic        do_finish;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_req;
    logic        dl_wait;
    logic        done;
    logic [24:0] rom_sz;
    logic [24:0] max_addr;
    logic        has_data;
    logic [15:0] data_swapped;

    // dl_q follows dl even in reset so a download still held high across reset never looks like a new start
    always_ff @(posedge mclk) begin
        dl_q <= bus.dl;
    end

    assign dl_rise      = bus.dl & ~dl_q;
    assign ack_match    = (wr_req == bus.wr_ack);
    assign data_swapped = {bus.dl_data[7:0], bus.dl_data[15:8]};

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_write   = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE: begin
                if (dl_rise) begin
                    do_start   = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (bus.dl_wr) begin
                    do_write   = 1'b1;
                    state_next = PEND;
                end else if (!bus.dl) begin
                    do_finish  = 1'b1;
                    state_next = IDLE;
                end
            end
            PEND: begin
                if (ack_match) begin
                    state_next = RECV;
                end else if (!bus.dl) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (ack_match) begin
                    do_finish  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding wr_req equal to wr_ack in reset guarantees no phantom write request on release
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_req   <= bus.wr_ack;
            dl_wait  <= 1'b0;
            done     <= 1'b0;
            rom_sz   <= '0;
            max_addr <= '0;
            has_data <= 1'b0;
        end else begin
            done    <= do_finish;
            dl_wait <= (state_next == PEND) || (state_next == DRAIN);
            if (do_start) begin
                max_addr <= '0;
                has_data <= 1'b0;
            end
            if (do_write) begin
                wr_addr  <= bus.dl_addr;
                wr_data  <= data_swapped;
                wr_req   <= ~wr_req;
                has_data <= 1'b1;
                if (!has_data || (bus.dl_addr > max_addr)) begin
                    max_addr <= bus.dl_addr;
                end
            end
            if (do_finish) begin
                rom_sz <= has_data ? (max_addr + 25'd2) : 25'd0;
            end
        end
    end

    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.wr_req  = wr_req;
    assign bus.dl_wait = dl_wait;
    assign bus.done    = done;
    assign bus.rom_sz  = rom_sz;

`ifdef CART_QUIRK_EN
    logic [7:0]  ser_first;
    logic [47:0] ser_mid;
    logic [5:0]  quirks;

    // Result bit order is {fifo,eeprom,sram,noram,pier,ttn2}
    function automatic logic [5:0] serial_quirks(input logic [63:0] serial);
        serial_quirks = 6'b000000;
        case (serial)
            "T-081276", "T-81406 ", "T-081586", "T-81576 ", "T-81476 ":
                serial_quirks = 6'b001000;
            "MK-1215 ", "G-4060  ", "00001211", "MK-1228 ", "G-5538  ",
            "00004076", "T-12046 ", "T-12053 ", "G-4524  ":
                serial_quirks = 6'b010000;
            "T-113016": serial_quirks = 6'b000100;
            "T-89016 ": serial_quirks = 6'b100000;
            "T-574023", "T-574013": serial_quirks = 6'b000010;
            "TITAN002": serial_quirks = 6'b000001;
            default: serial_quirks = 6'b000000;
        endcase
    endfunction

    // The 8-char serial spans bytes 0x183..0x18A of the image, first char in the top byte
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            ser_first <= '0;
            ser_mid   <= '0;
            quirks    <= '0;
        end else if (do_start) begin
            ser_first <= '0;
            ser_mid   <= '0;
            quirks    <= '0;
        end else if (do_write) begin
            case (bus.dl_addr)
                25'h182: ser_first      <= bus.dl_data[15:8];
                25'h184: ser_mid[47:32] <= data_swapped;
                25'h186: ser_mid[31:16] <= data_swapped;
                25'h188: ser_mid[15:0]  <= data_swapped;
                25'h18A: quirks <= quirks | serial_quirks({ser_first, ser_mid, bus.dl_data[7:0]});
                default: ;
            endcase
        end
    end

    assign bus.quirks = quirks;
`else
    assign bus.quirks = 6'b000000;
`endif
endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 MCLK  in  1  system clock; all logic rising-edge.
REQ-002 RESET_N  in  1  synchronous, active-low reset.
REQ-003 DL  in  1  cartridge download active (host stream framing).
REQ-004 DL_WR  in  1  one-cycle strobe; DL_ADDR/DL_DATA valid.
REQ-005 DL_ADDR  in  25  byte address of word, always even.
REQ-006 DL_DATA  in  16  word as delivered by host (little-endian byte order).
REQ-007 DL_WAIT  out  1  host stall; host issues no DL_WR while high.
REQ-008 WR_ADDR  out  25  write byte address to DDR3 ROM store.
REQ-009 WR_DATA  out  16  byte-swapped word {DL_DATA[7:0],DL_DATA[15:8]}.
REQ-010 WR_REQ  out  1  toggle request; new write when WR_REQ != WR_ACK.
REQ-011 WR_ACK  in  1  toggle acknowledge from DDR3 port.
REQ-012 ROM_SZ  out  25  loaded image size in bytes.
REQ-013 QUIRKS  out  6  {fifo,eeprom,sram,noram,pier,ttn2} per-title flags.
REQ-014 DONE  out  1  one-cycle pulse when a download fully completes.

Function
REQ-015 FSM states IDLE, RECV, PEND, DRAIN; reset state IDLE.
REQ-016 IDLE->RECV on DL 0->1 (registered edge); same transition clears QUIRKS and the max-address register.
REQ-017 RECV with DL_WR: latch WR_ADDR=DL_ADDR, WR_DATA=swapped DL_DATA, toggle WR_REQ, set DL_WAIT, go PEND; all visible 1 cycle after DL_WR.
REQ-018 PEND: when WR_REQ==WR_ACK, clear DL_WAIT and return to RECV in the same cycle.
REQ-019 DL_WR arriving in PEND or DRAIN is ignored; no second write issued.
REQ-020 DL 1->0 in RECV: ROM_SZ <= max written DL_ADDR + 2, pulse DONE, go IDLE.
REQ-021 DL 1->0 in PEND: go DRAIN, keep DL_WAIT high; on WR_REQ==WR_ACK, update ROM_SZ per REQ-020, clear DL_WAIT, pulse DONE, go IDLE.
REQ-022 Download with zero DL_WR strobes: ROM_SZ=0, DONE still pulses.
REQ-023 Max-address tracking is unsigned 25-bit; ROM_SZ add wraps mod 2^25 (address 0x1FFFFFE gives 0).
REQ-024 DL_WR while IDLE is ignored.
REQ-025 Header capture: DL_WR at 0x182 stores DL_DATA[15:8]; 0x184/0x186/0x188 store swapped words; 0x18A compares 8-char serial {captured,DL_DATA[7:0]}.
REQ-026 Serial table: "T-081276","T-81406 ","T-081586","T-81576 ","T-81476 " -> sram; "MK-1215 ","G-4060  ","00001211","MK-1228 ","G-5538  ","00004076","T-12046 ","T-12053 ","G-4524  " -> eeprom; "T-113016" -> noram; "T-89016 " -> fifo; "T-574023","T-574013" -> pier; "TITAN002" -> ttn2.
REQ-027 QUIRKS bits set only by match, persist until next download start or reset.

Reset
REQ-028 RESET_N low: state IDLE, DL_WAIT=0, DONE=0, ROM_SZ=0, QUIRKS=0, WR_ADDR=0, WR_DATA=0, WR_REQ<=WR_ACK (no spurious request).
REQ-029 Reset mid-download aborts it; no DONE; resumption requires a fresh DL 0->1 after reset release.

Configuration
REQ-030 Macro CART_QUIRK_EN: defined -> header capture and table per REQ-025..027; undefined -> capture/compare logic absent, QUIRKS constant 0, all other behaviour identical.

Verification
REQ-031 Write 0x1234 at 0x000, ack after 3 cycles -> WR_DATA=0x3412, WR_REQ toggles once, DL_WAIT high exactly until ack cycle.
REQ-032 Stream 0x000..0x1FE, drop DL -> ROM_SZ=0x200, one DONE pulse, 256 WR_REQ toggles.
REQ-033 Drop DL while ack outstanding -> DRAIN, DL_WAIT held, DONE on ack, ROM_SZ includes last word.
REQ-034 Header words spelling "T-89016 " at 0x182..0x18A -> QUIRKS=6'b100000; next download start -> QUIRKS=0.
REQ-035 RESET_N low during PEND with WR_ACK=1 -> WR_REQ=1, DL_WAIT=0, no DONE, ROM_SZ=0.
REQ-036 Without CART_QUIRK_EN, repeat REQ-034 -> QUIRKS stays 0, writes unchanged.
